// File: rtl/argmax_classifier.sv
// argmax_classifier: sequential argmax over a snapshot of the final layer's scores
// Ports: clk, rst (async active-high), start (level, acts on rising edge),
//   scores (signed per-class scores), busy (scan in progress),
//   result_valid (one-cycle pulse), class_idx / max_score (held winner).
// Optional macro ARGMAX_TOP2_EN adds second_idx (runner-up index) and
//   margin (max_score minus runner-up score, unsigned SCORE_BITS+1).
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_BITS  = 40,
    parameter int IDX_BITS    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [SCORE_BITS-1:0] scores [0:NUM_CLASSES-1],
    output logic                         busy,
    output logic                         result_valid,
`ifdef ARGMAX_TOP2_EN
    output logic [IDX_BITS-1:0]          second_idx,
    output logic [SCORE_BITS:0]          margin,
`endif
    output logic [IDX_BITS-1:0]          class_idx,
    output logic signed [SCORE_BITS-1:0] max_score
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(NUM_CLASSES - 1);
    state_t state, next_state;
    logic start_d, trig;
    logic signed [SCORE_BITS-1:0] snap [0:NUM_CLASSES-1];
    logic signed [SCORE_BITS-1:0] best_val;
    logic [IDX_BITS-1:0] best_idx, ptr;
`ifdef ARGMAX_TOP2_EN
    logic signed [SCORE_BITS-1:0] second_val;
    logic [IDX_BITS-1:0] second_ptr;
`endif
    assign trig = start & ~start_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end
    always_comb begin
        next_state = state == IDLE ? (trig ? SCAN : IDLE) :
                     state == SCAN ? (ptr == LAST ? DONE : SCAN) : IDLE;
    end
    always_comb begin
        busy = state == SCAN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d      <= 1'b0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            max_score    <= '0;
            best_val     <= '0;
            best_idx     <= '0;
            ptr          <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
`ifdef ARGMAX_TOP2_EN
            second_val   <= '0;
            second_ptr   <= '0;
            second_idx   <= '0;
            margin       <= '0;
`endif
        end else begin
            start_d      <= start;
            result_valid <= 1'b0;
            if (state == IDLE && trig) begin
                snap     <= scores;
                best_val <= scores[0];
                best_idx <= '0;
                ptr      <= IDX_BITS'(1);
`ifdef ARGMAX_TOP2_EN
                // Seeding the runner-up with element 1 lets the first compare
                // either keep it (not strictly greater than itself) or swap it.
                second_val <= scores[1];
                second_ptr <= IDX_BITS'(1);
`endif
            end else if (state == SCAN) begin
                if (snap[ptr] > best_val) begin
                    best_val <= snap[ptr];
                    best_idx <= ptr;
`ifdef ARGMAX_TOP2_EN
                    second_val <= best_val;
                    second_ptr <= best_idx;
                end else if (snap[ptr] > second_val) begin
                    second_val <= snap[ptr];
                    second_ptr <= ptr;
`endif
                end
                ptr <= ptr + IDX_BITS'(1);
            end else if (state == DONE) begin
                class_idx    <= best_idx;
                max_score    <= best_val;
                result_valid <= 1'b1;
`ifdef ARGMAX_TOP2_EN
                second_idx   <= second_ptr;
                // Sign-extend both so the difference cannot overflow.
                margin       <= {best_val[SCORE_BITS-1], best_val} - {second_val[SCORE_BITS-1], second_val};
`endif
            end
        end
    end
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: randomized and directed checks of argmax_classifier against a reference model
module tb_argmax_classifier;
    localparam int N  = 10;
    localparam int W  = 40;
    localparam int IW = 4;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic signed [W-1:0] scores [0:N-1];
    logic signed [W-1:0] sc [0:N-1];
    logic busy, result_valid;
    logic [IW-1:0] class_idx;
    logic signed [W-1:0] max_score;
    int checks = 0, errors = 0, pulses = 0;
    int exp_idx;
    logic signed [W-1:0] exp_val;
    localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
`ifdef ARGMAX_TOP2_EN
    logic [IW-1:0] second_idx;
    logic [W:0] margin;
    int exp_sec;
    logic signed [W-1:0] sec_val;
    logic [W:0] exp_margin;
`endif

    argmax_classifier #(.NUM_CLASSES(N), .SCORE_BITS(W), .IDX_BITS(IW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .scores(scores),
        .busy(busy),
        .result_valid(result_valid),
`ifdef ARGMAX_TOP2_EN
        .second_idx(second_idx),
        .margin(margin),
`endif
        .class_idx(class_idx),
        .max_score(max_score)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (result_valid) pulses++;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Winner = largest value; among equal values the first position wins.
    function automatic void model();
        exp_val = sc[0];
        foreach (sc[i]) if (sc[i] > exp_val) exp_val = sc[i];
        exp_idx = -1;
        foreach (sc[i]) if (exp_idx < 0 && sc[i] == exp_val) exp_idx = i;
`ifdef ARGMAX_TOP2_EN
        sec_val = MIN;
        foreach (sc[i]) if (i != exp_idx && sc[i] > sec_val) sec_val = sc[i];
        exp_sec = -1;
        foreach (sc[i]) if (exp_sec < 0 && i != exp_idx && sc[i] == sec_val) exp_sec = i;
        exp_margin = (W+1)'(exp_val) - (W+1)'(sec_val);
`endif
    endfunction

    // Present sc, raise start, return #1 after the trigger edge.
    task automatic launch();
        @(negedge clk);
        scores = sc;
        start = 1'b1;
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string tag, input bit hold);
        int lat = 0;
        int bc = 0;
        bc += int'(busy);
        if (!hold) start = 1'b0;
        else foreach (scores[i]) scores[i] = W'({$urandom(), $urandom()});
        while (!result_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bc += int'(busy);
        end
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_busy_cycles"}, bc, 9);
        chk({tag, "_class_idx"}, class_idx, exp_idx);
        chk({tag, "_max_score"}, max_score, exp_val);
`ifdef ARGMAX_TOP2_EN
        chk({tag, "_second_idx"}, second_idx, exp_sec);
        chk({tag, "_margin"}, margin, exp_margin);
`endif
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, result_valid, 0);
        chk({tag, "_idx_held"}, class_idx, exp_idx);
    endtask

    initial begin
        int p;
        foreach (sc[i]) sc[i] = '0;
        scores = sc;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_class_idx", class_idx, 0);
        chk("reset_max_score", max_score, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (sc[i]) sc[i] = W'(i * 100);
        launch();
        wait_result("ramp", 1'b0);

        foreach (sc[i]) sc[i] = -40'sd5;
        launch();
        wait_result("tie_neg5", 1'b0);

        foreach (sc[i]) sc[i] = MIN + 40'sd1;
        sc[3] = MIN;
        sc[7] = MAX;
        launch();
        wait_result("extreme_max", 1'b0);
        sc[7] = MIN + 40'sd1;
        launch();
        wait_result("extreme_tie", 1'b0);

        for (int k = 0; k < 6; k++) begin
            foreach (sc[i]) sc[i] = (k % 2 == 1) ? W'($urandom_range(0, 6)) - 40'sd3 : W'({$urandom(), $urandom()});
            launch();
            wait_result("random", 1'b0);
        end

        // Level held high across two results' worth of cycles; scores scrambled after trigger.
        foreach (sc[i]) sc[i] = W'({$urandom(), $urandom()});
        p = pulses;
        launch();
        wait_result("held", 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk("held_single_pulse", pulses - p, 1);
        chk("held_idx_stable", class_idx, exp_idx);
        @(negedge clk);
        start = 1'b0;

        // Reset at the 4th SCAN cycle with start still high.
        foreach (sc[i]) sc[i] = W'(i * 7 + 1);
        launch();
        wait_result("pre_reset", 1'b0);
        foreach (sc[i]) sc[i] = W'({$urandom(), $urandom()});
        p = pulses;
        launch();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_class_idx", class_idx, 0);
        chk("midrst_max_score", max_score, 0);
        foreach (sc[i]) sc[i] = W'({$urandom(), $urandom()}) >>> 3;
        scores = sc;
        model();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wait_result("after_reset", 1'b0);
        chk("midrst_pulses", pulses - p, 1);

`ifdef ARGMAX_TOP2_EN
        foreach (sc[i]) sc[i] = -40'sd1;
        sc[0] = 40'sd10;
        sc[4] = 40'sd50;
        sc[8] = 40'sd49;
        launch();
        wait_result("top2", 1'b0);
        chk("top2_second_const", second_idx, 8);
        chk("top2_margin_const", margin, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
